// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, ALU operation codes and the base-op lookup.
// The M-extension codes are always present; decoding them depends on RV32M_EN.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // M ops occupy 5'b10_xxx with the low bits equal to funct3.
  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_PASSB  = 5'd10,
    ALU_MUL    = 5'd16,
    ALU_MULH   = 5'd17,
    ALU_MULHSU = 5'd18,
    ALU_MULHU  = 5'd19,
    ALU_DIV    = 5'd20,
    ALU_DIVU   = 5'd21,
    ALU_REM    = 5'd22,
    ALU_REMU   = 5'd23
  } alu_op_t;

  function automatic alu_op_t base_alu(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate generator: picks the I/S/B/U/J format from the
// opcode and sign-extends from instr[31]. R-type instructions yield zero.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (instr[6:0])
      OPC_LUI, OPC_AUIPC: imm = {instr[31:12], 12'b0};
      OPC_JAL:    imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      OPC_BRANCH: imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_STORE:  imm = {{21{instr[31]}}, instr[30:25], instr[11:7]};
      OPC_OP:     imm = '0;
      default:    imm = {{21{instr[31]}}, instr[30:20]};
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I instruction-decode stage with load-use stall and flush handling.
// Define RV32M_EN to decode the M-extension (funct7 = 0000001) OP instructions.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_ready,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            r_enabled,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [4:0]      id_rd,
  output logic [XLEN-1:0] id_imm,
  output logic [4:0]      id_alu_op,
  output logic [2:0]      id_funct3,
  output logic            id_we,
  output logic            id_mem_rd,
  output logic            id_mem_wr,
  output logic            id_branch,
  output logic            id_jump,
  output logic            id_illegal
);

  typedef enum logic {RUN, STALL} state_t;

  state_t      state_reg, state_next;
  logic        hazard;
  logic        load_bundle;
  logic        clear_valid;
  logic [31:0] imm;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  alu_op_t     dec_alu;
  logic        dec_we, dec_mrd, dec_mwr, dec_br, dec_jmp, dec_ill;
  logic [4:0]  dec_rd;

  assign opc = if_instr[6:0];
  assign f3  = if_instr[14:12];
  assign f7  = if_instr[31:25];

  assign rs1_addr  = if_instr[19:15];
  assign rs2_addr  = if_instr[24:20];
  // id_rd is already zero for non-writing instructions, so no extra qualifier is needed.
  assign hazard    = id_valid & id_mem_rd & (id_rd != 5'd0) &
                     ((id_rd == rs1_addr) | (id_rd == rs2_addr)) & if_valid;
  assign if_ready  = (~id_valid | ex_ready) & (state_reg == RUN) & ~hazard;
  assign r_enabled = if_valid & if_ready;

  imm_gen u_imm_gen (
    .instr (if_instr[31:0]),
    .imm   (imm)
  );

  always_comb begin
    dec_alu = ALU_ADD;
    dec_we  = 1'b0;
    dec_mrd = 1'b0;
    dec_mwr = 1'b0;
    dec_br  = 1'b0;
    dec_jmp = 1'b0;
    dec_ill = 1'b0;
    case (opc)
      OPC_LUI: begin
        dec_we  = 1'b1;
        dec_alu = ALU_PASSB;
      end
      OPC_AUIPC: dec_we = 1'b1;
      OPC_JAL, OPC_JALR: begin
        dec_we  = 1'b1;
        dec_jmp = 1'b1;
      end
      OPC_BRANCH: begin
        dec_br  = 1'b1;
        dec_alu = ALU_SUB;
      end
      OPC_LOAD: begin
        dec_we  = 1'b1;
        dec_mrd = 1'b1;
      end
      OPC_STORE: dec_mwr = 1'b1;
      OPC_OP_IMM: begin
        dec_we  = 1'b1;
        dec_alu = base_alu(f3, (f3 == 3'b101) & if_instr[30]);
        if ((f3 == 3'b001 || f3 == 3'b101) && f7 != 7'b0000000 && f7 != 7'b0100000)
          dec_ill = 1'b1;
      end
      OPC_OP: begin
        dec_we = 1'b1;
        if (f7 == 7'b0000000)
          dec_alu = base_alu(f3, 1'b0);
        else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
          dec_alu = base_alu(f3, 1'b1);
        else if (f7 == 7'b0000001) begin
`ifdef RV32M_EN
          dec_alu = alu_op_t'({2'b10, f3});
`else
          dec_ill = 1'b1;
`endif
        end else
          dec_ill = 1'b1;
      end
      OPC_MISC_MEM, OPC_SYSTEM: dec_alu = ALU_ADD;
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_we  = 1'b0;
      dec_mrd = 1'b0;
      dec_mwr = 1'b0;
      dec_br  = 1'b0;
      dec_jmp = 1'b0;
    end
  end

  assign dec_rd = dec_we ? if_instr[11:7] : 5'd0;

  // Handshake FSM: flush wins, then the load-use bubble, then a normal transfer.
  always_comb begin
    state_next  = state_reg;
    load_bundle = 1'b0;
    clear_valid = 1'b0;
    if (flush) begin
      state_next  = RUN;
      clear_valid = 1'b1;
    end else begin
      case (state_reg)
        RUN: begin
          if (hazard & ex_ready) begin
            state_next  = STALL;
            clear_valid = 1'b1;
          end else if (if_valid & if_ready)
            load_bundle = 1'b1;
          else if (ex_ready)
            clear_valid = 1'b1;
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) state_reg <= RUN;
    else       state_reg <= state_next;
  end

  // A bubble only drops id_valid; the remaining fields keep their last contents.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      id_valid   <= 1'b0;
      id_pc      <= RESET_PC;
      id_rd      <= '0;
      id_imm     <= '0;
      id_alu_op  <= '0;
      id_funct3  <= '0;
      id_we      <= 1'b0;
      id_mem_rd  <= 1'b0;
      id_mem_wr  <= 1'b0;
      id_branch  <= 1'b0;
      id_jump    <= 1'b0;
      id_illegal <= 1'b0;
    end else if (load_bundle) begin
      id_valid   <= 1'b1;
      id_pc      <= if_pc;
      id_rd      <= dec_rd;
      id_imm     <= imm;
      id_alu_op  <= dec_alu;
      id_funct3  <= f3;
      id_we      <= dec_we;
      id_mem_rd  <= dec_mrd;
      id_mem_wr  <= dec_mwr;
      id_branch  <= dec_br;
      id_jump    <= dec_jmp;
      id_illegal <= dec_ill;
    end else if (clear_valid) begin
      id_valid   <= 1'b0;
    end
  end

endmodule
